alu_cmd_driver: RTL
===================

# alu_cmd_driver

Sequential command front-end for the combinational `ALU`. It accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the ALU operand/control inputs, captures `result`/`isZero`, and returns each outcome over a valid/ready response channel in strict command order. It is the initiating end of the ALU interface, used by multi-cycle datapath extensions and by self-checking benches.

## Interface

- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `TAGW`, 4: width of the command tag carried through to the response.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_op1`  in  32  first operand.
- `cmd_op2`  in  32  second operand.
- `cmd_ctrl`  in  4  ALU control code.
- `cmd_tag`  in  TAGW  user tag.
- `alu_op1`  out  32  to ALU `op1`.
- `alu_op2`  out  32  to ALU `op2`.
- `alu_control`  out  4  to ALU `alu_control`.
- `alu_result`  in  32  from ALU `result`.
- `alu_isZero`  in  1  from ALU `isZero`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  32  captured result.
- `rsp_zero`  out  1  captured zero flag.
- `rsp_err`  out  1  command used an illegal control code.
- `rsp_tag`  out  TAGW  tag of the command being answered.
- `issued_count`  out  16  number of completed ALU operations; wraps.

## Operation

- ALU control codes: AND=0000, OR=0001, ADD=0010, SUB=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001. Codes 1010–1111 are illegal.
- FIFO
  - Push on `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`. There is no bypass, so a full FIFO refuses a push even in a cycle where it pops.
  - Read and write pointers wrap modulo DEPTH. An occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
  - Push and pop in the same cycle leave occupancy unchanged.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into the operand/control/tag registers and go to DRIVE; otherwise stay.
  - DRIVE: the registers feed `alu_*` directly for one full cycle. At the next edge:
    - capture `alu_result` → `rsp_result` and `alu_isZero` → `rsp_zero`;
    - latch the tag;
    - set `rsp_valid`;
    - increment `issued_count`;
    - go to HOLD.
  - HOLD: `rsp_*` are stable while `rsp_valid && !rsp_ready`. On the handshake edge, `rsp_valid` falls. If the FIFO is non-empty at that edge, pop the next command and go straight to DRIVE; otherwise go to IDLE.
- Illegal code: the command is still driven for one DRIVE cycle. The response then has `rsp_err=1`, `rsp_result=0` and `rsp_zero=1`.
- `alu_op1`, `alu_op2` and `alu_control` hold their last values in IDLE and HOLD. They never change during DRIVE.
- `issued_count` counts legal and illegal operations alike and wraps FFFF→0000.
- Capacity: up to DEPTH+1 commands can be outstanding (DEPTH in the FIFO, one in DRIVE or HOLD).

## Timing

- Reset values:
  - `cmd_ready=1`, `rsp_valid=0`;
  - `rsp_result=0`, `rsp_zero=0`, `rsp_err=0`, `rsp_tag=0`;
  - `alu_op1=0`, `alu_op2=0`, `alu_control=0000`;
  - `issued_count=0`;
  - state IDLE, FIFO empty.
- Latency: a command accepted at edge E0 into an empty, idle block is popped at E1, captured at E2, and `rsp_valid` is high in the cycle after E2.
- Throughput: with `rsp_ready` held at 1 and the FIFO non-empty, one response every 2 cycles.
- Reset asserted mid-operation, at any edge, discards the FIFO, the in-flight command and any pending response. Every output returns to its reset value at that edge. No partial response is ever emitted.
- `cmd_*` inputs are sampled only at the push edge. `alu_result` and `alu_isZero` are sampled only at the DRIVE→HOLD edge.

## Test plan

- Reset, then send ADD (op1=15, op2=10, tag=1) → 2 cycles after acceptance: `rsp_result=25`, `rsp_zero=0`, `rsp_tag=1`, `issued_count=1`.
- Send SRA (op1=FFFF_FF80, op2=5) → `rsp_result=FFFF_FFFC`. Then SUB (7, 7) → `rsp_result=0`, `rsp_zero=1`.
- Hold `rsp_ready=0` and stream commands with tags 0..7 → exactly 5 accepted, then `cmd_ready=0`. Release `rsp_ready` → responses arrive with tags 0..4 in order, and `rsp_result` is stable while stalled.
- Send ctrl=1100 with op1=3, op2=4 → `rsp_err=1`, `rsp_result=0`, `rsp_zero=1`, `issued_count` increments. A following legal OR(0xF0, 0x0F) → `rsp_result=FF`, `rsp_err=0`.
- Push 3 commands, assert `reset` for one cycle during DRIVE of the first → all outputs at reset values on the next cycle and no response emitted. A fresh ADD(1, 1) then returns 2 with `issued_count=1`.
- Preload `issued_count` to FFFF via 65535 operations (or force), then one more ADD → `issued_count=0000`.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
//   Command front-end for the combinational ALU. Commands are buffered in a
//   small FIFO and issued one at a time. Each command is held on the ALU
//   inputs for one full cycle. The ALU outcome is then captured and returned,
//   in command order, over a valid/ready response channel.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready   command channel (op1, op2, 4-bit ctrl, tag)
//   o_alu_*               operands/control driven to the ALU
//   i_alu_result/isZero   ALU outputs, sampled at the end of the drive cycle
//   o_rsp_*/i_rsp_ready   response channel (result, zero, err, tag)
//   o_issued_count        completed ALU operations, wraps at 16 bits
module alu_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [31:0]     i_cmd_op1,
  input  logic [31:0]     i_cmd_op2,
  input  logic [3:0]      i_cmd_ctrl,
  input  logic [TAGW-1:0] i_cmd_tag,
  output logic [31:0]     o_alu_op1,
  output logic [31:0]     o_alu_op2,
  output logic [3:0]      o_alu_control,
  input  logic [31:0]     i_alu_result,
  input  logic            i_alu_isZero,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [31:0]     o_rsp_result,
  output logic            o_rsp_zero,
  output logic            o_rsp_err,
  output logic [TAGW-1:0] o_rsp_tag,
  output logic [15:0]     o_issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 32 + 32 + 4 + TAGW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_HOLD} state_t;

  // ---------------- command FIFO ----------------
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  logic          w_full, w_empty, w_push, w_pop;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // No bypass: a full FIFO refuses a push even when it pops this cycle.
  assign w_push  = i_cmd_valid && !w_full;
  assign w_head  = r_mem[r_rptr];
  assign o_cmd_ready = !w_full;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= {i_cmd_op1, i_cmd_op2, i_cmd_ctrl, i_cmd_tag};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- issue FSM ----------------
  state_t r_state, w_state_nxt;
  logic   w_capture, w_rsp_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (i_rsp_ready) begin
          w_rsp_done = 1'b1;
          // Chain straight into the next command to sustain 2 cycles/op.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_DRIVE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  logic [31:0]     r_op1, r_op2, r_rsp_result;
  logic [3:0]      r_ctrl;
  logic [TAGW-1:0] r_tag, r_rsp_tag;
  logic            r_rsp_valid, r_rsp_zero, r_rsp_err;
  logic [15:0]     r_issued;
  logic            w_illegal;

  // Legal codes are 0..9; 1010-1111 are rejected in the response.
  assign w_illegal = (r_ctrl > 4'd9);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op1        <= '0;
      r_op2        <= '0;
      r_ctrl       <= '0;
      r_tag        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_tag    <= '0;
      r_issued     <= '0;
    end else begin
      if (w_pop) {r_op1, r_op2, r_ctrl, r_tag} <= w_head;
      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= w_illegal ? 32'd0 : i_alu_result;
        r_rsp_zero   <= w_illegal ? 1'b1  : i_alu_isZero;
        r_rsp_err    <= w_illegal;
        r_rsp_tag    <= r_tag;
        r_issued     <= r_issued + 16'd1;
      end else if (w_rsp_done) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign o_alu_op1      = r_op1;
  assign o_alu_op2      = r_op2;
  assign o_alu_control  = r_ctrl;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_result   = r_rsp_result;
  assign o_rsp_zero     = r_rsp_zero;
  assign o_rsp_err      = r_rsp_err;
  assign o_rsp_tag      = r_rsp_tag;
  assign o_issued_count = r_issued;

endmodule
